// File: rtl/ram_fifo_controller.sv
// Byte-stream FIFO sequencer for a single-port 128x8 register-file memory.
// Pushes become memory writes and pops become prefetch reads into a registered head-of-queue byte.
module ram_fifo_controller #(
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] level,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [7:0]            mem_data_out
);

  typedef enum logic {
    PRIO_FETCH = 1'b0,
    PRIO_WRITE = 1'b1
  } prio_e;

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

  // State registers
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_out_valid;
  logic [7:0]            r_out_data;
  prio_e                 r_prio;

  // Next-state values
  logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic                  w_out_valid_next;
  logic [7:0]            w_out_data_next;
  prio_e                 w_prio_next;

  // Request and grant terms
  logic w_not_full;
  logic w_wreq;
  logic w_freq;
  logic w_grant_write;
  logic w_grant_fetch;
  logic w_pop;

  function automatic logic [ADDR_WIDTH-1:0] f_advance(input logic [ADDR_WIDTH-1:0] ptr);
    return (ptr == LP_LAST) ? '0 : ptr + 1'b1;
  endfunction

  // Requests are also gated by reset so the memory strobes drop the instant reset asserts.
  assign w_not_full = (r_count < LP_DEPTH);
  assign w_wreq     = reset && !flush && in_valid && w_not_full;
  assign w_freq     = reset && !flush && (r_count != '0) && (!r_out_valid || out_ready);
  assign w_pop      = r_out_valid && out_ready;

  assign w_grant_write = w_wreq && (!w_freq || (r_prio == PRIO_WRITE));
  assign w_grant_fetch = w_freq && (!w_wreq || (r_prio == PRIO_FETCH));

  assign in_ready = reset && !flush && w_not_full && (!w_freq || (r_prio == PRIO_WRITE));

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign level       = {1'b0, r_count} + {{(ADDR_WIDTH+1){1'b0}}, r_out_valid};
  assign mem_data_in = in_data;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    mem_address      = r_wr_ptr;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    if (w_grant_write) begin
      mem_write_enable = 1'b1;
    end else if (w_grant_fetch) begin
      mem_address     = r_rd_ptr;
      mem_read_enable = 1'b1;
    end
  end

  // Priority only flips on real contention, so an idle or one-sided cycle never costs a turn.
  always_comb begin
    w_prio_next = r_prio;
    if (w_wreq && w_freq) begin
      w_prio_next = (r_prio == PRIO_WRITE) ? PRIO_FETCH : PRIO_WRITE;
    end
  end

  always_comb begin
    w_wr_ptr_next    = r_wr_ptr;
    w_rd_ptr_next    = r_rd_ptr;
    w_count_next     = r_count;
    w_out_valid_next = r_out_valid;
    w_out_data_next  = r_out_data;

    if (flush) begin
      w_wr_ptr_next    = '0;
      w_rd_ptr_next    = '0;
      w_count_next     = '0;
      w_out_valid_next = 1'b0;
    end else if (w_grant_write) begin
      w_wr_ptr_next = f_advance(r_wr_ptr);
      w_count_next  = r_count + 1'b1;
      if (w_pop) begin
        w_out_valid_next = 1'b0;
      end
    end else if (w_grant_fetch) begin
      w_rd_ptr_next    = f_advance(r_rd_ptr);
      w_count_next     = r_count - 1'b1;
      w_out_data_next  = mem_data_out;
      w_out_valid_next = 1'b1;
    end else if (w_pop) begin
      w_out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prio <= PRIO_FETCH;
    end else begin
      r_prio <= w_prio_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_wr_ptr    <= w_wr_ptr_next;
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
    end
  end

endmodule

// File: tb/tb_ram_fifo_controller.sv
// Directed bench for ram_fifo_controller with a behavioural 128x8 memory attached.
// A vector table covers the early cycle-by-cycle behaviour; hand sequences cover fill, wrap, flush and reset.
module tb_ram_fifo_controller;

  logic       clock;
  logic       reset;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] level;
  logic [6:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_write_enable;
  logic       mem_read_enable;
  logic [7:0] mem_data_out;

  logic [7:0] mem [128];

  int n_cmp  = 0;
  int n_fail = 0;

  ram_fifo_controller #(.DEPTH(128), .ADDR_WIDTH(7)) dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .level            (level),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_data_out     (mem_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write_enable) mem[mem_address] <= mem_data_in;
  end
  assign mem_data_out = mem_read_enable ? mem[mem_address] : 8'h00;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [8:0] lvl;
    logic       we;
    logic       re;
    logic [6:0] addr;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic push_n(input int n_bytes, input logic [7:0] base);
    int n;
    n = 0;
    for (int cyc = 0; cyc < 1000 && n < n_bytes; cyc++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(n);
      @(negedge clock);
      if (in_ready) n++;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    check("push_count", 32'(n), 32'(n_bytes));
  endtask

  initial begin
    int         m;
    int         sent;
    int         got;
    logic [7:0] exp_q [$];
    logic [7:0] d;

    //            iv   id     ordy  ir    ov    od     lvl    we    re    addr
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 9'd0, 1'b1, 1'b0, 7'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 9'd1, 1'b0, 1'b1, 7'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 9'd1, 1'b0, 1'b0, 7'd1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 9'd1, 1'b0, 1'b0, 7'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 9'd0, 1'b0, 1'b0, 7'd1};
    vecs[5]  = '{1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 8'hA5, 9'd0, 1'b1, 1'b0, 7'd1};
    vecs[6]  = '{1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 8'hA5, 9'd1, 1'b0, 1'b1, 7'd1};
    vecs[7]  = '{1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 8'hB1, 9'd1, 1'b1, 1'b0, 7'd2};
    vecs[8]  = '{1'b1, 8'hB3, 1'b1, 1'b1, 1'b0, 8'hB1, 9'd1, 1'b1, 1'b0, 7'd3};
    vecs[9]  = '{1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 8'hB1, 9'd2, 1'b0, 1'b1, 7'd2};
    vecs[10] = '{1'b1, 8'hB4, 1'b1, 1'b1, 1'b1, 8'hB2, 9'd2, 1'b1, 1'b0, 7'd4};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hB2, 9'd2, 1'b0, 1'b1, 7'd3};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB3, 9'd2, 1'b0, 1'b1, 7'd4};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB4, 9'd1, 1'b0, 1'b0, 7'd5};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hB4, 9'd0, 1'b0, 1'b0, 7'd5};

    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    out_ready = 1'b1;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_we", 32'(mem_write_enable), 32'd0);
    check("rst_re", 32'(mem_read_enable), 32'd0);

    // Single byte, pop, then write/fetch contention
    do_reset();
    for (int i = 0; i < 15; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      @(negedge clock);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d_we", i), 32'(mem_write_enable), 32'(vecs[i].we));
      check($sformatf("vec%0d_re", i), 32'(mem_read_enable), 32'(vecs[i].re));
      check($sformatf("vec%0d_addr", i), 32'(mem_address), 32'(vecs[i].addr));
      check($sformatf("vec%0d_mem_din", i), 32'(mem_data_in), 32'(vecs[i].id));
      @(posedge clock);
      #1;
    end

    // Fill to full capacity (128 in memory + 1 in output register), then drain in order
    do_reset();
    push_n(129, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge clock);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_we", 32'(mem_write_enable), 32'd0);
    check("full_level", 32'(level), 32'd129);
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    m = 0;
    for (int cyc = 0; cyc < 400 && m < 129; cyc++) begin
      @(negedge clock);
      if (out_valid) begin
        check("drain_data", 32'(out_data), 32'(m));
        m++;
      end
      @(posedge clock);
      #1;
    end
    check("drain_count", 32'(m), 32'd129);
    @(negedge clock);
    check("drain_level", 32'(level), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1;

    // Wrap-around with out_ready toggling each cycle
    do_reset();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 3000 && got < 300; cyc++) begin
      d         = 8'(sent * 7 + 3);
      in_valid  = (sent < 300);
      in_data   = d;
      out_ready = ((cyc % 2) == 1);
      @(negedge clock);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("wrap_unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("wrap_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        got++;
      end
      @(posedge clock);
      #1;
    end
    check("wrap_count", 32'(got), 32'd300);
    in_valid = 1'b0;

    // Flush with level 5 while a push is offered
    do_reset();
    push_n(5, 8'h40);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("pre_flush_level", 32'(level), 32'd5);
    @(posedge clock);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(negedge clock);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_we", 32'(mem_write_enable), 32'd0);
    check("flush_re", 32'(mem_read_enable), 32'd0);
    @(posedge clock);
    #1;
    flush   = 1'b0;
    in_data = 8'h3C;
    @(negedge clock);
    check("post_flush_level", 32'(level), 32'd0);
    check("post_flush_out_valid", 32'(out_valid), 32'd0);
    check("post_flush_in_ready", 32'(in_ready), 32'd1);
    check("post_flush_we", 32'(mem_write_enable), 32'd1);
    check("post_flush_addr", 32'(mem_address), 32'd0);
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("post_flush_re", 32'(mem_read_enable), 32'd1);
    check("post_flush_fetch_addr", 32'(mem_address), 32'd0);
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    check("post_flush_out_data", 32'(out_data), 32'h3C);
    check("post_flush_valid", 32'(out_valid), 32'd1);
    @(posedge clock);
    #1;

    // Asynchronous reset mid-burst, between clock edges
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(8'h90 + i);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    check("pre_reset_we", 32'(mem_write_enable), 32'd1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_level", 32'(level), 32'd0);
    check("async_we", 32'(mem_write_enable), 32'd0);
    check("async_re", 32'(mem_read_enable), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_controller.md
Name: ram_fifo_controller

Overview:
- Single-port sequencer that sits directly upstream of the 128x8 register-file memory.
- Turns a byte stream with a valid/ready handshake into a circular FIFO held in that memory: pushes become memory writes, pops become memory reads.
- Drives the memory's address, data-in, read-enable and write-enable lines.
- Makes at most one memory access per cycle and arbitrates between pushes and prefetches.

Parameters:
- DEPTH, 128, number of memory locations used; any value from 2 to 2^ADDR_WIDTH.
- ADDR_WIDTH, 7, memory address width.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of FIFO contents.
- in_data  input  8  push data.
- in_valid  input  1  push request.
- in_ready  output  1  push accepted this cycle when in_valid && in_ready.
- out_data  output  8  head-of-queue byte (registered).
- out_valid  output  1  out_data holds valid data.
- out_ready  input  1  consumer takes out_data when out_valid && out_ready.
- level  output  ADDR_WIDTH+2  bytes stored; equals count + out_valid.
- mem_address  output  ADDR_WIDTH  memory address.
- mem_data_in  output  8  memory write data; always equals in_data.
- mem_write_enable  output  1  memory write strobe; memory captures the write on the rising clock edge.
- mem_read_enable  output  1  memory read strobe.
- mem_data_out  input  8  memory read data; combinational from the address while mem_read_enable is high.

Behaviour:
- Clock and reset: one clock, named clock. Reset is named reset, asynchronous and active-low.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0, prio=FETCH.
- count: bytes held in memory only, excluding the output register; width ADDR_WIDTH+1.
- Combinational requests each cycle:
  - wreq = in_valid && count<DEPTH.
  - freq = count>0 && (!out_valid || out_ready).
- Arbitration:
  - Only one of wreq/freq asserted: it is granted.
  - Both asserted: the grant goes to prio. prio then flips to the other side, so neither side starves.
  - Neither asserted: no access; prio unchanged.
- in_ready = count<DEPTH && (!freq || prio==WRITE). in_ready depends combinationally on out_ready.
- Write grant:
  - mem_address=wr_ptr, mem_write_enable=1.
  - At the clock edge: wr_ptr advances, count increments.
- Fetch grant:
  - mem_address=rd_ptr, mem_read_enable=1.
  - At the clock edge: out_data<=mem_data_out, out_valid<=1, rd_ptr advances, count decrements.
- No grant: both memory enables are 0 and mem_address=wr_ptr.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. DEPTH need not be a power of two.
- Pop without refill: out_valid && out_ready with no fetch granted that cycle -> out_valid<=0 at the edge.
- Pop with refill: a fetch granted in the same cycle as a pop replaces out_data seamlessly. out_valid stays 1, giving 1 byte/cycle throughput when not contending with writes.
- Ordering: bytes leave in exact push order.
- Latency: a byte pushed into an empty FIFO in cycle N is written at the end of N, fetched in N+1, and appears on out_data/out_valid after the N+1 edge. Minimum 2 cycles.
- Full: count==DEPTH forces in_ready=0 and stalls the producer. Total capacity is DEPTH+1 bytes, including the output register.
- Empty: count==0 and out_valid==0 gives level=0; no memory access is issued.
- flush:
  - Synchronously sets wr_ptr=0, rd_ptr=0, count=0, out_valid=0.
  - Overrides any push or pop in the same cycle: in_ready=0 and both memory enables=0 while flush is high.
  - prio and out_data are retained.
- Reset mid-operation: all state returns to reset values immediately, independent of clock; memory enables drop to 0. Memory contents are not cleared, but they are unreachable because the pointers are 0.

Test Plan:
- Reset and single byte: release reset, push 0xA5 in cycle 0 with out_ready=1 -> mem_write_enable=1 at address 0 in cycle 0; mem_read_enable=1 at address 0 in cycle 1; out_data=0xA5, out_valid=1 after the cycle-1 edge; level=1, then 0 after the pop.
- Fill to full (DEPTH=128): hold out_ready=0 and push 0x00..0x80 -> 129 bytes accepted (1 prefetched into out_data, 128 in memory); in_ready=0 afterwards; level=129. Then pop all -> sequence 0x00..0x80 in order, ending with level=0.
- Wrap-around: cycle 300 bytes through with out_ready toggling every cycle -> wr_ptr and rd_ptr wrap 127->0 without data loss; output matches input order exactly.
- Contention fairness: in_valid=1 and out_ready=1 continuously with count>0 -> grants alternate write/fetch every cycle; in_ready toggles 1,0,1,0.
- Flush: with level=5, assert flush for one cycle alongside in_valid=1 -> level=0, out_valid=0, in_ready=0 during flush, no memory write that cycle; next push of 0x3C lands at address 0.
- Async reset: drop reset mid-burst between clock edges -> out_valid, level and both memory enables go to 0 immediately, before the next clock edge.
